// File: rtl/pid_gain_regfile.sv
// PID gain register file: host writes staged in shadow registers, committed atomically to the active set on sample_tick.
// Build option REGS_SHADOW_READ_EN: gain reads return the staged shadow value instead of the active value.
module pid_gain_regfile #(
    parameter int                NUM_REGS  = 3,
    parameter int                DATA_W    = 6,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          reg_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       sample_tick,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       addr_err,
    output logic                       commit_pending,
    output logic                       committed,
    output logic [NUM_REGS*DATA_W-1:0] gains
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [ADDR_W-1:0] CSR_OFF = ADDR_W'(NUM_REGS);

    logic [ADDR_W-1:0] offset;
    logic              hit_gain;
    logic              hit_csr;
    logic              wr_fire;
    logic              rd_fire;
    logic              commit_req;
    logic              abort_req;
    logic              apply;
    logic [0:0]        state;
    logic [DATA_W-1:0] rd_mux;

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    // Unsigned wrap: addresses below BASE_ADDR land on huge offsets and decode as errors.
    assign offset   = reg_addr - BASE_ADDR;
    assign hit_gain = (offset < CSR_OFF);
    assign hit_csr  = (offset == CSR_OFF);
    assign wr_fire  = ena & wr_en;
    assign rd_fire  = ena & rd_en;

    assign commit_req = wr_fire & hit_csr & wr_data[0];
    assign abort_req  = wr_fire & hit_csr & wr_data[1];

    // An abort arriving with the tick cancels the commit rather than racing it.
    assign apply = (state == PENDING) & sample_tick & ~abort_req;

    assign commit_pending = (state == PENDING);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (commit_req && !abort_req) state <= PENDING;
                PENDING: if (abort_req || sample_tick) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the gain arrays are small and must read as zero after reset, so they are reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            committed <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            committed <= apply;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (apply) active[i] <= shadow[i];
                if (wr_fire && hit_gain && (offset == ADDR_W'(i))) shadow[i] <= wr_data;
            end
        end
    end

    // NOTE: every output of this combinational block gets a default first so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        if (hit_gain) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (offset == ADDR_W'(i)) begin
`ifdef REGS_SHADOW_READ_EN
                    rd_mux = shadow[i];
`else
                    rd_mux = active[i];
`endif
                end
            end
        end else if (hit_csr) begin
            rd_mux = {{(DATA_W-1){1'b0}}, commit_pending};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            addr_err <= (rd_fire | wr_fire) & ~(hit_gain | hit_csr);
            if (rd_fire) rd_data <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign gains[g*DATA_W +: DATA_W] = active[g];
    end

endmodule

// File: tb/tb_pid_gain_regfile.sv
// Scoreboard bench for pid_gain_regfile: a reference model predicts each cycle, read results queue until rd_valid.
module tb_pid_gain_regfile;

    localparam int          NUM_REGS = 3;
    localparam int          DATA_W   = 6;
    localparam int          ADDR_W   = 8;
    localparam logic [7:0]  BASE     = 8'h10;
    localparam logic [7:0]  CSR      = BASE + 8'd3;

    logic                       clk;
    logic                       rst;
    logic                       ena;
    logic                       wr_en;
    logic                       rd_en;
    logic [ADDR_W-1:0]          reg_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       sample_tick;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       addr_err;
    logic                       commit_pending;
    logic                       committed;
    logic [NUM_REGS*DATA_W-1:0] gains;

    pid_gain_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .reg_addr      (reg_addr),
        .wr_data       (wr_data),
        .sample_tick   (sample_tick),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .addr_err      (addr_err),
        .commit_pending(commit_pending),
        .committed     (committed),
        .gains         (gains)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_sh  [NUM_REGS];
    logic [DATA_W-1:0] m_act [NUM_REGS];
    logic              m_pend;
    logic [DATA_W-1:0] m_rd;
    logic [DATA_W-1:0] rd_q [$];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_gains();
        logic [NUM_REGS*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_act[i];
        return f;
    endfunction

    // One clock of stimulus; the model advances alongside and every output is compared after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] addr,
                        input logic [DATA_W-1:0] data, input logic tick, input string tag);
        logic [7:0]        off;
        logic              g, c, fw, fr, req, abt, exp_err, exp_commit;
        logic [DATA_W-1:0] exp_rd, got;
        off = addr - BASE;
        g   = (off < 8'd3);
        c   = (off == 8'd3);
        fw  = ena & w;
        fr  = ena & r;
        exp_rd = '0;
        if (g) begin
`ifdef REGS_SHADOW_READ_EN
            exp_rd = m_sh[int'(off)];
`else
            exp_rd = m_act[int'(off)];
`endif
        end else if (c) begin
            exp_rd = {{(DATA_W-1){1'b0}}, m_pend};
        end
        if (fr) begin
            rd_q.push_back(exp_rd);
            m_rd = exp_rd;
        end
        exp_err    = (fw | fr) & ~(g | c);
        req        = fw & c & data[0];
        abt        = fw & c & data[1];
        exp_commit = 1'b0;
        if (m_pend) begin
            if (abt) m_pend = 1'b0;
            else if (tick) begin
                for (int i = 0; i < NUM_REGS; i++) m_act[i] = m_sh[i];
                exp_commit = 1'b1;
                m_pend     = 1'b0;
            end
        end else if (req && !abt) begin
            m_pend = 1'b1;
        end
        if (fw && g) m_sh[int'(off)] = data;

        wr_en = w; rd_en = r; reg_addr = addr; wr_data = data; sample_tick = tick;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0; sample_tick = 1'b0;

        vectors++;
        if (gains !== model_gains()) begin
            miscompares++;
            $display("FAIL %s gains: got %h want %h", tag, gains, model_gains());
        end
        vectors++;
        if (commit_pending !== m_pend) begin
            miscompares++;
            $display("FAIL %s commit_pending: got %b want %b", tag, commit_pending, m_pend);
        end
        vectors++;
        if (committed !== exp_commit) begin
            miscompares++;
            $display("FAIL %s committed: got %b want %b", tag, committed, exp_commit);
        end
        vectors++;
        if (addr_err !== exp_err) begin
            miscompares++;
            $display("FAIL %s addr_err: got %b want %b", tag, addr_err, exp_err);
        end
        vectors++;
        if (rd_valid !== fr) begin
            miscompares++;
            $display("FAIL %s rd_valid: got %b want %b", tag, rd_valid, fr);
        end
        if (rd_valid === 1'b1 && rd_q.size() > 0) begin
            got = rd_q.pop_front();
            vectors++;
            if (rd_data !== got) begin
                miscompares++;
                $display("FAIL %s rd_data: got %h want %h", tag, rd_data, got);
            end
        end else if (fr && rd_q.size() > 0) begin
            void'(rd_q.pop_front());
        end
        vectors++;
        if (rd_data !== m_rd) begin
            miscompares++;
            $display("FAIL %s rd_data hold: got %h want %h", tag, rd_data, m_rd);
        end
    endtask

    task automatic do_reset(input logic tick);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; sample_tick = tick;
        reg_addr = '0; wr_data = '0;
        cycle();
        rst = 1'b0; sample_tick = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_pend = 1'b0;
        m_rd   = '0;
        rd_q.delete();
        vectors++;
        if (gains !== '0 || commit_pending !== 1'b0 || committed !== 1'b0 ||
            rd_valid !== 1'b0 || addr_err !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got gains=%h pend=%b cmt=%b rv=%b err=%b rd=%h want all zero",
                     gains, commit_pending, committed, rd_valid, addr_err, rd_data);
        end
    endtask

    task automatic test_reset();
        ena = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, BASE + 8'(i), '0, 1'b0, "reset_read");
        step(1'b0, 1'b0, BASE, '0, 1'b0, "reset_idle");
    endtask

    task automatic test_shadow_write();
        step(1'b1, 1'b0, BASE, 6'h15, 1'b0, "shadow_wr");
        step(1'b0, 1'b1, BASE, '0, 1'b0, "shadow_rd");
        vectors++;
`ifdef REGS_SHADOW_READ_EN
        if (rd_data !== 6'h15 || gains !== '0) begin
`else
        if (rd_data !== 6'h00 || gains !== '0) begin
`endif
            miscompares++;
            $display("FAIL shadow_isolation: got rd=%h gains=%h", rd_data, gains);
        end
    endtask

    task automatic test_commit();
        step(1'b1, 1'b0, BASE,        6'h15, 1'b0, "commit_wr0");
        step(1'b1, 1'b0, BASE + 8'd1, 6'h2A, 1'b0, "commit_wr1");
        step(1'b1, 1'b0, BASE + 8'd2, 6'h3F, 1'b0, "commit_wr2");
        step(1'b1, 1'b0, CSR,         6'h01, 1'b0, "commit_req");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, BASE, '0, 1'b0, "commit_wait");
        step(1'b0, 1'b1, CSR, '0, 1'b0, "csr_read_pending");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "commit_tick");
        vectors++;
        if (gains !== {6'h3F, 6'h2A, 6'h15} || committed !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_apply: got gains=%h cmt=%b want 3f2a15/1", gains, committed);
        end
        step(1'b0, 1'b0, BASE, '0, 1'b0, "commit_after");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, BASE + 8'(i), '0, 1'b0, "commit_readback");
    endtask

    task automatic test_tick_same_cycle();
        step(1'b1, 1'b0, BASE,        6'h01, 1'b0, "same_wr0");
        step(1'b1, 1'b0, BASE + 8'd1, 6'h02, 1'b0, "same_wr1");
        step(1'b1, 1'b0, BASE + 8'd2, 6'h03, 1'b0, "same_wr2");
        step(1'b1, 1'b0, CSR,         6'h01, 1'b1, "same_req_tick");
        vectors++;
        if (gains !== {6'h3F, 6'h2A, 6'h15} || commit_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL req_with_tick: got gains=%h pend=%b want 3f2a15/1", gains, commit_pending);
        end
        step(1'b0, 1'b0, BASE, '0, 1'b0, "same_idle");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "same_next_tick");
        vectors++;
        if (gains !== {6'h03, 6'h02, 6'h01}) begin
            miscompares++;
            $display("FAIL deferred_commit: got %h want 030201", gains);
        end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b0, BASE + 8'd1, 6'h07, 1'b0, "abort_wr");
        step(1'b1, 1'b0, CSR, 6'h01, 1'b0, "abort_req");
        step(1'b1, 1'b0, CSR, 6'h02, 1'b0, "abort_cancel");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "abort_tick");
        vectors++;
        if (gains !== {6'h03, 6'h02, 6'h01} || committed !== 1'b0 || commit_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: got gains=%h cmt=%b pend=%b want 030201/0/0", gains, committed, commit_pending);
        end
        step(1'b1, 1'b0, CSR, 6'h03, 1'b0, "abort_wins");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "abort_wins_tick");
    endtask

    task automatic test_addr_err();
        step(1'b1, 1'b0, BASE + 8'd4, 6'h3F, 1'b0, "err_wr_base4");
        step(1'b1, 1'b0, 8'hFF,       6'h3F, 1'b0, "err_wr_ff");
        step(1'b1, 1'b0, BASE - 8'd1, 6'h3F, 1'b0, "err_wr_below");
        step(1'b0, 1'b1, BASE + 8'd1, '0,    1'b0, "err_pre_read");
        step(1'b0, 1'b1, BASE + 8'd4, '0,    1'b0, "err_rd_base4");
        step(1'b0, 1'b1, 8'hFF,       '0,    1'b0, "err_rd_ff");
        vectors++;
        if (rd_data !== '0 || addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_read: got rd=%h err=%b want 00/1", rd_data, addr_err);
        end
        step(1'b1, 1'b0, CSR, 6'h01, 1'b0, "err_commit_req");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "err_commit_tick");
        vectors++;
        if (gains !== {6'h03, 6'h07, 6'h01}) begin
            miscompares++;
            $display("FAIL err_no_side_effect: got %h want 030701", gains);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, BASE + 8'd2, 6'h20, 1'b0, "b2b_wr2");
        step(1'b1, 1'b0, CSR,         6'h01, 1'b0, "b2b_req");
        step(1'b1, 1'b0, BASE,        6'h11, 1'b1, "b2b_wr_with_tick");
        vectors++;
        if (gains !== {6'h20, 6'h07, 6'h01}) begin
            miscompares++;
            $display("FAIL wr_with_tick: got %h want 200701", gains);
        end
        step(1'b1, 1'b0, CSR, 6'h01, 1'b0, "b2b_req2");
        step(1'b0, 1'b0, BASE, '0, 1'b1, "b2b_tick2");
        vectors++;
        if (gains !== {6'h20, 6'h07, 6'h11}) begin
            miscompares++;
            $display("FAIL late_write_commit: got %h want 200711", gains);
        end
        step(1'b1, 1'b1, BASE + 8'd1, 6'h2C, 1'b0, "b2b_rw1");
        step(1'b1, 1'b1, BASE + 8'd1, 6'h0E, 1'b0, "b2b_rw2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, BASE + 8'(i), '0, 1'b0, "b2b_reads");
    endtask

    task automatic test_ena();
        ena = 1'b0;
        step(1'b1, 1'b1, BASE, 6'h3F, 1'b0, "ena_off_rw");
        step(1'b1, 1'b0, CSR,  6'h01, 1'b0, "ena_off_csr");
        step(1'b1, 1'b1, 8'hFF, 6'h3F, 1'b0, "ena_off_err");
        ena = 1'b1;
        step(1'b1, 1'b0, CSR, 6'h01, 1'b0, "ena_req");
        ena = 1'b0;
        step(1'b0, 1'b0, BASE, '0, 1'b1, "ena_off_tick");
        vectors++;
        if (gains !== {6'h20, 6'h0E, 6'h11}) begin
            miscompares++;
            $display("FAIL commit_without_ena: got %h want 200e11", gains);
        end
        ena = 1'b1;
    endtask

    task automatic test_rst_pending();
        step(1'b1, 1'b0, BASE, 6'h2A, 1'b0, "rst_wr");
        step(1'b1, 1'b0, CSR,  6'h01, 1'b0, "rst_req");
        do_reset(1'b1);
        step(1'b0, 1'b0, BASE, '0, 1'b1, "rst_tick_after");
        step(1'b0, 1'b1, BASE, '0, 1'b0, "rst_read");
    endtask

    initial begin
        ena = 1'b1; rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        reg_addr = '0; wr_data = '0; sample_tick = 1'b0;
        test_reset();
        test_shadow_write();
        test_commit();
        test_tick_same_cycle();
        test_abort();
        test_addr_err();
        test_back_to_back();
        test_ena();
        test_rst_pending();
        vectors++;
        if (rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding want 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
